// File: rtl/serial_add_sub_if.sv
// serial_add_sub_if -- request/result bundle for the serial adder/subtractor.
//
// Handshake: a request is offered by raising start together with a, b and sub.
// The block accepts it on a rising clk edge whenever busy is low (IDLE or DONE).
// While busy is high, start is ignored. done is a one-cycle pulse that qualifies
// sum, cout and ovf. These results then hold until the next accepted start.
//
// Signals:
//   start  request a new operation
//   a, b   operands (WIDTH bits)
//   sub    0 = a+b, 1 = a-b
//   busy   operation in progress
//   done   one-cycle result strobe
//   sum    result modulo 2^WIDTH
//   cout   raw carry out of the MSB
//   ovf    two's-complement overflow
//
// Modports: master drives requests, slave is the adder itself.
interface serial_add_sub_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             sub;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output start, a, b, sub,
    input  busy, done, sum, cout, ovf
  );

  modport slave (
    input  start, a, b, sub,
    output busy, done, sum, cout, ovf
  );
endinterface

// File: rtl/serial_add_sub.sv
// serial_add_sub -- chunk-serial adder/subtractor.
//
// The block processes CHUNK bits per cycle, starting with the LSB chunk. A full
// operation takes N = WIDTH/CHUNK RUN cycles followed by one DONE cycle.
// Subtraction is computed as a + ~b + 1. The +1 enters as the initial carry.
//
// Parameters:
//   WIDTH  operand/result width
//   CHUNK  bits per cycle; WIDTH must be a multiple of CHUNK, CHUNK >= 1
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   bus        serial_add_sub_if slave: start/a/b/sub in, busy/done/sum/cout/ovf out
//   dbg_state  current FSM state (0 = IDLE, 1 = RUN, 2 = DONE)
//
// Optional feature:
//   SERIAL_ADD_SUB_OVF_EN  when defined, the signed-overflow register is built.
//                          When undefined, ovf is tied to 0.
module serial_add_sub #(
  parameter int WIDTH = 8,
  parameter int CHUNK = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  serial_add_sub_if.slave       bus,
  output logic [1:0]            dbg_state
);

  localparam int N  = WIDTH / CHUNK;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             sub_q;
  logic             carry_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;

  // Current chunk slice and its add result
  logic [CHUNK-1:0] a_c;
  logic [CHUNK-1:0] b_c;
  logic [CHUNK-1:0] r_c;
  logic             c_out;
  logic             last_chunk;

  always_comb begin
    a_c = a_q[cnt_q*CHUNK +: CHUNK];
    // Inverting b here, together with carry_q loaded with sub, gives a - b
    b_c = b_q[cnt_q*CHUNK +: CHUNK] ^ {CHUNK{sub_q}};
    {c_out, r_c} = {1'b0, a_c} + {1'b0, b_c} + {{CHUNK{1'b0}}, carry_q};
    last_chunk = (cnt_q == CW'(N - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sub_q   <= 1'b0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          // A start in the DONE cycle is accepted, which gives one result every N+1 cycles.
          if (bus.start) begin
            a_q     <= bus.a;
            b_q     <= bus.b;
            sub_q   <= bus.sub;
            carry_q <= bus.sub;
            cnt_q   <= '0;
            state   <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          sum_q[cnt_q*CHUNK +: CHUNK] <= r_c;
          carry_q <= c_out;
          if (last_chunk) begin
            cout_q <= c_out;
            state  <= DONE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SERIAL_ADD_SUB_OVF_EN
  logic ovf_q;
  logic msb_cin;

  // The carry into the MSB is recovered from the MSB's own sum bit.
  assign msb_cin = a_c[CHUNK-1] ^ b_c[CHUNK-1] ^ r_c[CHUNK-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else if (state == RUN && last_chunk) begin
      ovf_q <= msb_cin ^ c_out;
    end
  end

  assign bus.ovf = ovf_q;
`else
  assign bus.ovf = 1'b0;
`endif

  assign bus.busy  = (state == RUN);
  assign bus.done  = (state == DONE);
  assign bus.sum   = sum_q;
  assign bus.cout  = cout_q;
  assign dbg_state = state;

endmodule

// File: tb/tb_serial_add_sub.sv
// tb_serial_add_sub -- self-checking bench for serial_add_sub (WIDTH=8, CHUNK=2).
// Expected ovf follows SERIAL_ADD_SUB_OVF_EN: the table values apply when it is
// defined, and ovf is expected to be 0 otherwise.
module tb_serial_add_sub;

  localparam int WIDTH = 8;
  localparam int CHUNK = 2;
  localparam int N     = WIDTH / CHUNK;
  localparam int W     = WIDTH + 2;   // {cout, ovf, sum}

`ifdef SERIAL_ADD_SUB_OVF_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic       clk;
  logic       rst_n;
  logic [1:0] dbg_state;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  serial_add_sub_if #(.WIDTH(WIDTH)) bus ();

  serial_add_sub #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int tests;
  int fails;
  int done_cnt;
  logic [W-1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: plain integer arithmetic on the whole operands.
  function automatic logic [W-1:0] model(input logic [7:0] a, input logic [7:0] b, input logic s);
    int ua, ub, sa, sb, r, sr;
    logic cout, ovf;
    logic [7:0] sum;
    ua = a;
    ub = b;
    sa = $signed(a);
    sb = $signed(b);
    if (s) begin
      r    = ua - ub;
      sr   = sa - sb;
      cout = (ua >= ub);
    end else begin
      r    = ua + ub;
      sr   = sa + sb;
      cout = (r > 255);
    end
    sum = r[7:0];
    ovf = OVF_EN && ((sr > 127) || (sr < -128));
    return {cout, ovf, sum};
  endfunction

  // Result monitor: every done pulse must match the oldest expected result.
  always @(negedge clk) begin
    if (rst_n && bus.done) begin
      done_cnt++;
      check("done_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0)
        check("result", 32'({bus.cout, bus.ovf, bus.sum}), 32'(exp_q.pop_front()));
    end
  end

  // ---------------- vectors ----------------
  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       sub;
    logic [7:0] sum;
    logic       cout;
    logic       ovf;   // value with overflow enabled
  } vec_t;

  vec_t vecs[8];

  // ---------------- driver tasks ----------------
  task automatic scramble_inputs();
    bus.a   = 8'($urandom);
    bus.b   = 8'($urandom);
    bus.sub = 1'($urandom);
  endtask

  // Full directed transaction with latency, pulse width and hold checks.
  task automatic run_vec(input vec_t v);
    logic [W-1:0] e;
    e = {v.cout, v.ovf & OVF_EN, v.sum};
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = v.a;
    bus.b     = v.b;
    bus.sub   = v.sub;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    scramble_inputs();
    for (int i = 0; i < N; i++) begin
      @(negedge clk);
      check("busy_in_run", 32'(bus.busy), 32'd1);
    end
    @(negedge clk);
    check("done_latency", 32'(bus.done), 32'd1);
    check("busy_in_done", 32'(bus.busy), 32'd0);
    @(negedge clk);
    check("done_one_cycle", 32'(bus.done), 32'd0);
    check("sum_hold", 32'(bus.sum), 32'(v.sum));
    check("cout_hold", 32'(bus.cout), 32'(v.cout));
    check("ovf_hold", 32'(bus.ovf), 32'(v.ovf & OVF_EN));
  endtask

  task automatic wait_not_busy();
    int guard;
    guard = 0;
    @(negedge clk);
    while (bus.busy && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    check("busy_timeout", 32'(bus.busy), 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, 32'(bus.busy), 32'd0);
    check({tag, "_done"}, 32'(bus.done), 32'd0);
    check({tag, "_sum"},  32'(bus.sum),  32'd0);
    check({tag, "_cout"}, 32'(bus.cout), 32'd0);
    check({tag, "_ovf"},  32'(bus.ovf),  32'd0);
    check({tag, "_state"}, 32'(dbg_state), 32'd0);
  endtask

  // ---------------- test ----------------
  initial begin
    int d0;
    int guard;
    logic [15:0] mask;
    logic [7:0] corner[4];
    logic [7:0] ra, rb;
    logic rs;

    tests    = 0;
    fails    = 0;
    done_cnt = 0;
    corner[0] = 8'h00;
    corner[1] = 8'h7F;
    corner[2] = 8'h80;
    corner[3] = 8'hFF;

    vecs[0] = '{8'h0A, 8'h05, 1'b0, 8'h0F, 1'b0, 1'b0};
    vecs[1] = '{8'h3B, 8'h65, 1'b1, 8'hD6, 1'b0, 1'b0};
    vecs[2] = '{8'h65, 8'h3B, 1'b1, 8'h2A, 1'b1, 1'b0};
    vecs[3] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
    vecs[4] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
    vecs[5] = '{8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1};
    vecs[6] = '{8'h00, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0};
    vecs[7] = '{8'hFF, 8'hFF, 1'b0, 8'hFE, 1'b1, 1'b0};

    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    bus.sub   = 1'b0;
    rst_n     = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;

    // Directed table
    foreach (vecs[i]) run_vec(vecs[i]);

    // Start during RUN is ignored; exactly one done
    wait_not_busy();
    d0 = done_cnt;
    bus.start = 1'b1;
    bus.a = 8'h65; bus.b = 8'h3B; bus.sub = 1'b1;
    exp_q.push_back(model(8'h65, 8'h3B, 1'b1));
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(negedge clk);
    bus.start = 1'b1;
    bus.a = 8'h11; bus.b = 8'h22; bus.sub = 1'b0;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (N + 4) @(negedge clk);
    check("single_done", 32'(done_cnt - d0), 32'd1);

    // Reset mid-RUN aborts with no done
    wait_not_busy();
    bus.start = 1'b1;
    bus.a = 8'hFF; bus.b = 8'hFF; bus.sub = 1'b0;
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check_all_zero("abort");
    @(negedge clk);
    rst_n = 1'b1;
    d0 = done_cnt;
    repeat (N + 4) @(negedge clk);
    check("no_done_after_abort", 32'(done_cnt - d0), 32'd0);
    run_vec(vecs[3]);

    // Start held high: a done every N+1 cycles
    wait_not_busy();
    @(negedge clk);
    repeat (3) exp_q.push_back(model(8'h3B, 8'h65, 1'b1));
    bus.start = 1'b1;
    bus.a = 8'h3B; bus.b = 8'h65; bus.sub = 1'b1;
    mask = '0;
    @(posedge clk);
    for (int i = 1; i <= 15; i++) begin
      @(negedge clk);
      mask[i] = bus.done;
      if (i == 10) begin
        @(posedge clk); #1;
        bus.start = 1'b0;
      end
    end
    check("back_to_back_period", 32'(mask), 32'h8420);

    // Randomized traffic against the model
    for (int n = 0; n < 40; n++) begin
      wait_not_busy();
      repeat ($urandom_range(1, 0)) @(negedge clk);
      ra = ($urandom_range(3, 0) == 0) ? corner[$urandom_range(3, 0)] : 8'($urandom);
      rb = ($urandom_range(3, 0) == 0) ? corner[$urandom_range(3, 0)] : 8'($urandom);
      rs = 1'($urandom);
      bus.start = 1'b1;
      bus.a = ra; bus.b = rb; bus.sub = rs;
      exp_q.push_back(model(ra, rb, rs));
      @(posedge clk); #1;
      bus.start = 1'b0;
      scramble_inputs();
    end

    // Drain
    guard = 0;
    while (exp_q.size() != 0 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/serial_add_sub.md
SERIAL_ADD_SUB -- requirements
Module: Serial_Add_Sub

Interface
REQ-001 WIDTH, 8: operand and result width in bits.
REQ-002 CHUNK, 2: bits processed per clock cycle; WIDTH SHALL be an integer multiple of CHUNK, and CHUNK SHALL be at least 1.
REQ-003 CLK  input  1  rising-edge clock; sole clock domain.
REQ-004 RST  input  1  asynchronous, active-low reset.
REQ-005 Start  input  1  request a new operation; sampled on the rising CLK edge.
REQ-006 A  input  WIDTH  first operand; sampled only on the accepting Start edge.
REQ-007 B  input  WIDTH  second operand; sampled only on the accepting Start edge.
REQ-008 Sub  input  1  0 = A+B, 1 = A-B; sampled only on the accepting Start edge.
REQ-009 Busy  output  1  high while the operation is in progress.
REQ-010 Done  output  1  one-cycle pulse marking valid Sum, Cout and Ovf.
REQ-011 Sum  output  WIDTH  result, modulo 2^WIDTH.
REQ-012 Cout  output  1  raw carry out of the MSB.
REQ-013 Ovf  output  1  two's-complement signed overflow of the operation.

Function
REQ-014 The block SHALL implement the three-state FSM IDLE, RUN, DONE.
REQ-015 In IDLE or DONE, Start=1 SHALL latch A, B and Sub, clear the chunk counter, load the carry register with Sub, and enter RUN.
REQ-016 Start SHALL be ignored while in RUN; the latched operands SHALL NOT change until the operation completes.
REQ-017 Each RUN cycle SHALL add chunk i of A to chunk i of (Sub ? ~B : B) plus the carry register, LSB chunk first, and write the CHUNK-bit result into Sum[i*CHUNK +: CHUNK].
REQ-018 Each RUN cycle SHALL store the chunk carry-out in the carry register for the next chunk.
REQ-019 After N = WIDTH/CHUNK RUN cycles, the FSM SHALL enter DONE for exactly one cycle and then return to IDLE, unless Start is accepted in that DONE cycle.
REQ-020 Latency: if Start is accepted at edge k, Done SHALL be high in the cycle following edge k+N.
REQ-021 Busy SHALL equal (state==RUN), and Done SHALL equal (state==DONE).
REQ-022 Cout SHALL be the carry out of the final chunk; for subtraction it SHALL equal 1 exactly when A>=B (unsigned).
REQ-023 Ovf SHALL be 1 exactly when the MSB carry-in differs from the MSB carry-out of the final chunk.
REQ-024 Sum, Cout and Ovf SHALL hold their values from DONE until the next accepted Start.
REQ-025 Partial values of Sum during RUN are don't-care to consumers; only values qualified by Done are valid.
REQ-026 Start accepted in the DONE cycle SHALL begin a new operation on that edge, giving back-to-back throughput of one result per N+1 cycles.
REQ-027 With CHUNK = WIDTH, the block SHALL complete in one RUN cycle (N=1).

Reset
REQ-028 While RST=0, state SHALL be IDLE and Busy, Done, Sum, Cout, Ovf, the carry register, the chunk counter and the latched operands SHALL all be 0, independent of CLK.
REQ-029 Asserting RST during RUN SHALL abort the operation; no Done pulse SHALL be produced for the aborted operation.
REQ-030 The first Start after RST deassertion SHALL be accepted normally.

Configuration
REQ-031 Macro SERIAL_ADD_SUB_OVF_EN defined: the Ovf logic and register SHALL be compiled in and behave per REQ-023.
REQ-032 Macro SERIAL_ADD_SUB_OVF_EN undefined: the Ovf port SHALL remain present and SHALL be driven constant 0, with no overflow logic synthesised.

Verification (WIDTH=8, CHUNK=2, SERIAL_ADD_SUB_OVF_EN defined unless noted)
REQ-033 A=0x0A, B=0x05, Sub=0, Start at edge k -> Busy for 4 cycles; Done high after edge k+4; Sum=0x0F, Cout=0, Ovf=0.
REQ-034 A=0x3B, B=0x65, Sub=1 -> Sum=0xD6, Cout=0, Ovf=0; A=0x65, B=0x3B, Sub=1 -> Sum=0x2A, Cout=1, Ovf=0.
REQ-035 A=0x7F, B=0x01, Sub=0 -> Sum=0x80, Cout=0, Ovf=1; A=0xFF, B=0x01, Sub=0 -> Sum=0x00, Cout=1, Ovf=0; same runs without the macro -> Ovf=0 throughout.
REQ-036 Start pulsed with new operands during RUN -> ignored; the result matches the original operands, and exactly one Done pulse is produced.
REQ-037 RST pulled low for one cycle mid-RUN -> all outputs 0 immediately and no Done pulse; a subsequent Start computes correctly.
REQ-038 Start held high continuously with fixed operands -> a Done pulse every 5 cycles with the correct, stable Sum.
